// File: rtl/opicorv32_pcpi_pkg.sv
// Shared constants and types for the PCPI multiply/divide coprocessor.
// Contents: the RV32M/RV64M opcode and funct7 constants, the funct3 op enum
// and the FSM state enum.
package opicorv32_pcpi_pkg;

    localparam logic [6:0] PCPI_OPCODE_OP = 7'b0110011;
    localparam logic [6:0] PCPI_FUNCT7_MD = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/opicorv32_pcpi_muldiv_if.sv
// PCPI bus between the core and a coprocessor.
// master (core): drives pcpi_valid/insn/rs1/rs2, receives wr/rd/wait/ready.
// slave (coprocessor): the reverse.
interface opicorv32_pcpi_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );
endinterface

// File: rtl/opicorv32_pcpi_mul_step.sv
// Combinational shift-add slice: retires STEPS multiplier bits in one pass.
// Ports: acc_i (running sum), mcand_i (multiplicand aligned to the current
// bit position), mplier_i (next STEPS multiplier bits, LSB first),
// acc_o (updated sum, modulo 2^W).
module opicorv32_pcpi_mul_step #(
    parameter int unsigned W     = 64,
    parameter int unsigned STEPS = 1
) (
    input  logic [W-1:0]     acc_i,
    input  logic [W-1:0]     mcand_i,
    input  logic [STEPS-1:0] mplier_i,
    output logic [W-1:0]     acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < int'(STEPS); i++) begin
            if (mplier_i[i]) begin
                acc_o = acc_o + (mcand_i << i);
            end
        end
    end

endmodule

// File: rtl/opicorv32_pcpi_muldiv.sv
// PCPI coprocessor for RV32M/RV64M multiply and divide.
// Parameters: XLEN (32/64), MUL_STEPS (multiplier bits per cycle).
// Ports: clk, reset (async active-high), pcpi (slave side of the PCPI bus).
// Optional feature: define OPICORV32_PCPI_DIV_EN to include the restoring
// divider (funct3 4..7); without it those encodings are never claimed.
module opicorv32_pcpi_muldiv
    import opicorv32_pcpi_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MUL_STEPS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    opicorv32_pcpi_muldiv_if.slave pcpi
);

    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(2 * XLEN + 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     mcand_q, mcand_d;
    logic [DW-1:0]     mplier_q, mplier_d;
    logic              wait_q, wait_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   rd_q, rd_d;

    logic [DW-1:0]     acc_step;
    logic [XLEN-1:0]   result;
    logic              insn_match;
    op_e               insn_op;
    logic              sgn_a, sgn_b;
    logic              unused_insn;

    assign insn_op     = op_e'(pcpi.pcpi_insn[14:12]);
    assign unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

    // Decode; only feeds the next-state logic, never an output directly.
    always_comb begin
        insn_match = pcpi.pcpi_valid
                     && (pcpi.pcpi_insn[6:0]   == PCPI_OPCODE_OP)
                     && (pcpi.pcpi_insn[31:25] == PCPI_FUNCT7_MD);
`ifndef OPICORV32_PCPI_DIV_EN
        insn_match = insn_match && !pcpi.pcpi_insn[14];
`endif
    end

    // Operand extension: signed forms sign-extend to 2*XLEN so the high word is exact.
    assign sgn_a = (insn_op == OP_MULH) || (insn_op == OP_MULHSU);
    assign sgn_b = (insn_op == OP_MULH);

    opicorv32_pcpi_mul_step #(
        .W     (DW),
        .STEPS (MUL_STEPS)
    ) u_mul_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q[MUL_STEPS-1:0]),
        .acc_o    (acc_step)
    );

`ifdef OPICORV32_PCPI_DIV_EN
    logic [XLEN-1:0] div_rem_q, div_rem_d;
    logic [XLEN-1:0] div_quo_q, div_quo_d;
    logic [XLEN-1:0] div_den_q, div_den_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_trial;
    logic [XLEN-1:0] rem_step, quo_step;
    logic [XLEN-1:0] quo_final, rem_final;
    logic            div_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {div_rem_q, div_quo_q[XLEN-1]};
        rem_trial = rem_shift - {1'b0, div_den_q};
        if (!rem_trial[XLEN]) begin
            rem_step = rem_trial[XLEN-1:0];
            quo_step = {div_quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[XLEN-1:0];
            quo_step = {div_quo_q[XLEN-2:0], 1'b0};
        end
        quo_final = neg_quo_q ? (XLEN'(0) - quo_step) : quo_step;
        rem_final = neg_rem_q ? (XLEN'(0) - rem_step) : rem_step;
    end

    // Magnitudes of the incoming operands for the signed forms.
    always_comb begin
        div_signed = (insn_op == OP_DIV) || (insn_op == OP_REM);
        a_neg      = div_signed && pcpi.pcpi_rs1[XLEN-1];
        b_neg      = div_signed && pcpi.pcpi_rs2[XLEN-1];
        a_mag      = a_neg ? (XLEN'(0) - pcpi.pcpi_rs1) : pcpi.pcpi_rs1;
        b_mag      = b_neg ? (XLEN'(0) - pcpi.pcpi_rs2) : pcpi.pcpi_rs2;
    end
`endif

    // Result mux for the final RUN cycle, using the post-step datapath values.
    always_comb begin
        result = '0;
        case (op_q)
            OP_MUL:                        result = acc_step[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = acc_step[DW-1:XLEN];
`ifdef OPICORV32_PCPI_DIV_EN
            OP_DIV, OP_DIVU:               result = quo_final;
            OP_REM, OP_REMU:               result = rem_final;
`endif
            default:                       result = '0;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        wait_d   = 1'b0;
        ready_d  = 1'b0;
        rd_d     = '0;
`ifdef OPICORV32_PCPI_DIV_EN
        div_rem_d = div_rem_q;
        div_quo_d = div_quo_q;
        div_den_d = div_den_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (insn_match) begin
                    state_d  = ST_RUN;
                    wait_d   = 1'b1;
                    op_d     = insn_op;
                    acc_d    = '0;
                    mcand_d  = {{XLEN{sgn_a & pcpi.pcpi_rs1[XLEN-1]}}, pcpi.pcpi_rs1};
                    mplier_d = {{XLEN{sgn_b & pcpi.pcpi_rs2[XLEN-1]}}, pcpi.pcpi_rs2};
                    case (insn_op)
                        OP_MUL:                       cnt_d = CNT_W'(XLEN / MUL_STEPS);
                        OP_MULH, OP_MULHSU, OP_MULHU: cnt_d = CNT_W'(DW / MUL_STEPS);
                        default:                      cnt_d = CNT_W'(XLEN);
                    endcase
`ifdef OPICORV32_PCPI_DIV_EN
                    div_rem_d = '0;
                    div_quo_d = a_mag;
                    div_den_d = b_mag;
                    neg_quo_d = (a_neg ^ b_neg) && (pcpi.pcpi_rs2 != '0);
                    neg_rem_d = a_neg;
`endif
                end
            end
            ST_RUN: begin
                if (!pcpi.pcpi_valid) begin
                    // Core withdrew the instruction: drop it silently.
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << MUL_STEPS;
                    mplier_d = mplier_q >> MUL_STEPS;
                    cnt_d    = cnt_q - CNT_W'(1);
`ifdef OPICORV32_PCPI_DIV_EN
                    div_rem_d = rem_step;
                    div_quo_d = quo_step;
`endif
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        rd_d    = result;
                    end else begin
                        wait_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            wait_q   <= 1'b0;
            ready_q  <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            wait_q   <= wait_d;
            ready_q  <= ready_d;
            rd_q     <= rd_d;
        end
    end

`ifdef OPICORV32_PCPI_DIV_EN
    // Divider registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_den_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
            div_den_q <= div_den_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign pcpi.pcpi_wait  = wait_q;
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = ready_q;
    assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_opicorv32_pcpi_muldiv.sv
// Self-checking bench for opicorv32_pcpi_muldiv (XLEN=32, MUL_STEPS=4).
// Divider checks follow OPICORV32_PCPI_DIV_EN: with it, divide corners are
// checked; without it, DIV must never be claimed.
module tb_opicorv32_pcpi_muldiv;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] sb_q[$];

    opicorv32_pcpi_muldiv_if #(.XLEN(XLEN)) bus ();

    opicorv32_pcpi_muldiv #(
        .XLEN      (XLEN),
        .MUL_STEPS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pcpi  (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {7'b0000001, 10'h0, f3, 5'd1, 7'b0110011};
    endfunction

    function automatic int lat(input logic [2:0] f3);
        if (f3 == 3'd0) return 8;
        if (f3 < 3'd4)  return 16;
        return 32;
    endfunction

    // Reference model of the RISC-V M-extension results.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, ub;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one instruction, push its expected result, and check the response.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd);
        int   n, cyc;
        bit   seen, busy_bad;
        logic [31:0] e;
        n = lat(f3);
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(f3);
        bus.pcpi_rs1   = a;
        bus.pcpi_rs2   = b;
        sb_q.push_back(exp_rd);
        @(posedge clk);
        cyc = 0; seen = 0; busy_bad = 0;
        while (!seen && cyc < n + 4) begin
            @(negedge clk);
            cyc++;
            if (bus.pcpi_ready) begin
                seen = 1;
                e = sb_q.pop_front();
                chk({tag, ".latency"}, 64'(cyc), 64'(n + 1));
                chk({tag, ".wr"}, 64'(bus.pcpi_wr), 64'd1);
                chk({tag, ".wait_in_ready"}, 64'(bus.pcpi_wait), 64'd0);
                chk({tag, ".rd"}, 64'(bus.pcpi_rd), 64'(e));
            end else if (!bus.pcpi_wait || bus.pcpi_wr || bus.pcpi_rd != '0) begin
                busy_bad = 1;
            end
        end
        if (!seen) begin
            chk({tag, ".timeout"}, 64'd0, 64'd1);
            sb_q.delete();
        end
        chk({tag, ".busy_phase"}, 64'(busy_bad), 64'd0);
        // Valid is still high here; the DONE cycle must not have re-triggered.
        @(negedge clk);
        chk({tag, ".no_retrigger"}, 64'({bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}), 64'd0);
        bus.pcpi_valid = 1'b0;
    endtask

    // Hold an instruction valid for 40 cycles; nothing may respond.
    task automatic hold_unclaimed(input string tag, input logic [31:0] insn);
        bit any;
        any = 0;
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = 32'd100;
        bus.pcpi_rs2   = 32'd7;
        repeat (40) begin
            @(negedge clk);
            if (bus.pcpi_wait || bus.pcpi_ready || bus.pcpi_wr || bus.pcpi_rd != '0) any = 1;
        end
        chk(tag, 64'(any), 64'd0);
        bus.pcpi_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        bit          any;

        reset          = 1'b1;
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = '0;
        bus.pcpi_rs1   = '0;
        bus.pcpi_rs2   = '0;
        repeat (2) @(negedge clk);
        chk("reset.outputs", 64'({bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}), 64'd0);
        chk("reset.rd", 64'(bus.pcpi_rd), 64'd0);
        reset = 1'b0;

        do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        do_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

`ifdef OPICORV32_PCPI_DIV_EN
        do_op("div_by0", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
        do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
        do_op("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        do_op("rem_neg", 3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
`else
        hold_unclaimed("div_unclaimed", mk_insn(3'd4));
        hold_unclaimed("remu_unclaimed", mk_insn(3'd7));
`endif

        // Abort: MULHU withdrawn in cycle T+3.
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(3'd3);
        bus.pcpi_rs1   = 32'h1234_5678;
        bus.pcpi_rs2   = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        chk("abort.wait_t1", 64'(bus.pcpi_wait), 64'd1);
        @(negedge clk);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        @(negedge clk);
        chk("abort.wait_t4", 64'(bus.pcpi_wait), 64'd0);
        any = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.pcpi_ready || bus.pcpi_wr || bus.pcpi_wait) any = 1;
        end
        chk("abort.no_ready", 64'(any), 64'd0);
        do_op("mul_after_abort", 3'd0, 32'd3, 32'd5, 32'd15);

        hold_unclaimed("add_unclaimed", 32'h0000_0033);
        hold_unclaimed("custom_unclaimed", 32'h0200_000B);

        // Reset in the middle of a MUL.
        @(negedge clk);
        bus.pcpi_valid = 1'b1;
        bus.pcpi_insn  = mk_insn(3'd0);
        bus.pcpi_rs1   = 32'd9;
        bus.pcpi_rs2   = 32'd9;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.wait_before", 64'(bus.pcpi_wait), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.outputs", 64'({bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}), 64'd0);
        chk("rst_mid.rd", 64'(bus.pcpi_rd), 64'd0);
        @(negedge clk);
        bus.pcpi_valid = 1'b0;
        reset          = 1'b0;
        do_op("mul_after_reset", 3'd0, 32'd2, 32'd3, 32'd6);

        // A few random operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = $urandom();
`ifdef OPICORV32_PCPI_DIV_EN
            rf = 3'($urandom_range(7, 0));
`else
            rf = 3'($urandom_range(3, 0));
`endif
            do_op("random", rf, ra, rb, ref_op(rf, ra, rb));
        end

        chk("scoreboard.empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
